// File: rtl/banked_program_memory.sv
// Banked program memory: instruction fetch port plus load/store data port
// over NUM_BANKS byte-laned BRAM banks, one-cycle registered read latency.
// Accesses beyond NUM_BANKS*WORDS_PER_BANK raise a one-cycle fault instead of
// aliasing onto a bank.
// Optional feature macro: PMEM_CLEAR_ON_RESET_EN (zero-fill sweep after reset).
//
// state  | meaning
// CLEAR  | sweeping zeros into one offset of every bank per cycle, busy=1
// READY  | normal fetch/load/store service, busy=0
module banked_program_memory #(
  parameter int WORDS_PER_BANK = 2048,
  parameter int NUM_BANKS      = 4,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [29:0]             PC,
  input  logic [29:0]             address,
  input  logic                    ren,
  input  logic                    wen,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_select_vector,
  output logic [DATA_WIDTH-1:0]   instr,
  output logic                    instr_valid,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    pc_fault,
  output logic                    addr_fault,
  output logic                    busy
);

  localparam int OFF_W  = $clog2(WORDS_PER_BANK);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int BSEL_W = (BANK_W > 0) ? BANK_W : 1;
  localparam int LANES  = DATA_WIDTH / 8;
  localparam logic [31:0] DEPTH = 32'(NUM_BANKS * WORDS_PER_BANK);

  logic [OFF_W-1:0]  pc_off, a_off;
  logic [BSEL_W-1:0] pc_bank, a_bank;
  logic              pc_in, a_in;
  logic              fetch_en, load_en, store_ok, a_fault_next;
  logic              clear_en;
  logic [OFF_W-1:0]  clear_off;

  logic [NUM_BANKS*DATA_WIDTH-1:0] ird_flat, drd_flat;
  logic [BSEL_W-1:0] isel_q, dsel_q;
  logic              izero_q, dzero_q;

  assign pc_off  = PC[OFF_W-1:0];
  assign a_off   = address[OFF_W-1:0];
  assign pc_bank = (NUM_BANKS == 1) ? '0 : PC[OFF_W +: BSEL_W];
  assign a_bank  = (NUM_BANKS == 1) ? '0 : address[OFF_W +: BSEL_W];
  // In range only when every bit above the bank field is zero.
  assign pc_in   = {2'b00, PC} < DEPTH;
  assign a_in    = {2'b00, address} < DEPTH;

  assign fetch_en     = !busy;
  assign load_en      = ren && !busy;
  assign store_ok     = wen && !busy && a_in && (|byte_select_vector);
  assign a_fault_next = !busy && !a_in && (ren || (wen && (|byte_select_vector)));

`ifdef PMEM_CLEAR_ON_RESET_EN
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]       state_q;
  logic [OFF_W-1:0] cnt_q;

  // Sweep sequencer: one offset per cycle, counter parks on the last offset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else if (state_q == S_CLEAR) begin
      if (cnt_q == OFF_W'(WORDS_PER_BANK - 1)) state_q <= S_READY;
      else                                     cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign busy      = (state_q == S_CLEAR);
  assign clear_en  = busy;
  assign clear_off = cnt_q;
`else
  assign busy      = 1'b0;
  assign clear_en  = 1'b0;
  assign clear_off = '0;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic bank_hit;
    assign bank_hit = (a_bank == BSEL_W'(b));

    for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [7:0]       lane_mem [WORDS_PER_BANK];
      logic [7:0]       ird_q, drd_q;
      logic             we;
      logic [OFF_W-1:0] woff;
      logic [7:0]       wbyte;

      assign we    = clear_en || (store_ok && bank_hit && byte_select_vector[j]);
      assign woff  = clear_en ? clear_off : a_off;
      assign wbyte = clear_en ? 8'h00 : data_in[8*j +: 8];

      // Byte-lane BRAM: read-first on both read ports, write gated per lane.
      always_ff @(posedge clk) begin
        if (we)       lane_mem[woff] <= wbyte;
        if (fetch_en) ird_q <= lane_mem[pc_off];
        if (load_en)  drd_q <= lane_mem[a_off];
      end

      assign ird_flat[b*DATA_WIDTH + 8*j +: 8] = ird_q;
      assign drd_flat[b*DATA_WIDTH + 8*j +: 8] = drd_q;
    end
  end

  // Status and mux-select registers captured alongside the BRAM reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid <= 1'b0;
      pc_fault    <= 1'b0;
      izero_q     <= 1'b1;
      isel_q      <= '0;
      data_valid  <= 1'b0;
      addr_fault  <= 1'b0;
      dzero_q     <= 1'b1;
      dsel_q      <= '0;
    end else begin
      instr_valid <= fetch_en;
      pc_fault    <= fetch_en && !pc_in;
      izero_q     <= !(fetch_en && pc_in);
      if (fetch_en) isel_q <= pc_bank;
      data_valid  <= load_en;
      addr_fault  <= a_fault_next;
      if (load_en) begin
        dsel_q  <= a_bank;
        dzero_q <= !a_in;
      end
    end
  end

  // Output muxes: forced to zero for faults, idle fetches and reset.
  always_comb begin
    instr    = '0;
    data_out = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!izero_q && isel_q == BSEL_W'(b)) instr    = ird_flat[b*DATA_WIDTH +: DATA_WIDTH];
      if (!dzero_q && dsel_q == BSEL_W'(b)) data_out = drd_flat[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule
